// File: rtl/judge_scan_ctrl.sv
// judge_scan_ctrl: match-stage sequencer for plate recognition.
// For each character position it walks every template through the shared
// difference engine (req/ack), keeps the lowest-difference template, strobes
// that result to the position's voter, and pulses frame_done at frame end.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; outputs quiet
//   REQ   | cmp_req high for (pos, tpl); advances tpl on each cmp_ack
//   EMIT  | one cycle; char_valid[pos] carries the winning template
//   DONE  | one cycle; frame_done high, then back to IDLE

module judge_scan_ctrl #(
    parameter int NUM_POS = 7,
    parameter int NUM_TPL = 16,
    parameter int DIFF_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                cmp_req,
    output logic [2:0]          cmp_pos,
    output logic [3:0]          cmp_tpl,
    input  logic                cmp_ack,
    input  logic [DIFF_W-1:0]   cmp_diff,
    output logic [3:0]          char_index,
    output logic [DIFF_W-1:0]   char_diff,
    output logic [NUM_POS-1:0]  char_valid,
    output logic                frame_done
);

    localparam logic [2:0] LAST_POS = 3'(NUM_POS - 1);
    localparam logic [3:0] LAST_TPL = 4'(NUM_TPL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state;
    logic [2:0]          pos;
    logic [3:0]          tpl;
    logic [DIFF_W-1:0]   best_diff;
    logic [3:0]          best_idx;

    logic                cand_better;
    logic [DIFF_W-1:0]   merged_diff;
    logic [3:0]          merged_idx;
    logic [NUM_POS-1:0]  pos_onehot;

    // Fold the returning difference into the running best. Strict less-than
    // means a tie keeps the earlier (lower) template index.
    always_comb begin
        cand_better = (cmp_diff < best_diff);
        merged_diff = best_diff;
        merged_idx  = best_idx;
        if (cand_better) begin
            merged_diff = cmp_diff;
            merged_idx  = tpl;
        end
    end

    // One-hot strobe pattern for the current position.
    always_comb begin
        pos_onehot = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            pos_onehot[i] = (pos == 3'(i));
        end
    end

    // Request-side outputs are decoded straight from registered state so the
    // engine sees the new template in the cycle right after an ack.
    always_comb begin
        busy    = (state != ST_IDLE);
        cmp_req = (state == ST_REQ);
        cmp_pos = cmp_req ? pos : 3'd0;
        cmp_tpl = cmp_req ? tpl : 4'd0;
    end

    // Sequencer: state, counters, running best and registered result outputs.
    // The result registers are loaded on the final ack so that they are
    // already valid during the EMIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pos        <= 3'd0;
            tpl        <= 4'd0;
            best_diff  <= '1;
            best_idx   <= 4'd0;
            char_index <= 4'd0;
            char_diff  <= '0;
            char_valid <= '0;
            frame_done <= 1'b0;
        end else begin
            char_valid <= '0;
            frame_done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pos       <= 3'd0;
                            tpl       <= 4'd0;
                            best_diff <= '1;
                            best_idx  <= 4'd0;
                            state     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (cmp_ack) begin
                            best_diff <= merged_diff;
                            best_idx  <= merged_idx;
                            if (tpl == LAST_TPL) begin
                                char_valid <= pos_onehot;
                                char_index <= merged_idx;
                                char_diff  <= merged_diff;
                                state      <= ST_EMIT;
                            end else begin
                                tpl <= tpl + 4'd1;
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (pos == LAST_POS) begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            pos       <= pos + 3'd1;
                            tpl       <= 4'd0;
                            best_diff <= '1;
                            best_idx  <= 4'd0;
                            state     <= ST_REQ;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_judge_scan_ctrl.sv
// Bench for judge_scan_ctrl: table of frame scenarios plus hand-written
// abort, restart and reset sequences.

module tb_judge_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        cmp_req;
    logic [2:0]  cmp_pos;
    logic [3:0]  cmp_tpl;
    logic        cmp_ack;
    logic [15:0] cmp_diff;
    logic [3:0]  char_index;
    logic [15:0] char_diff;
    logic [6:0]  char_valid;
    logic        frame_done;

    int n_checks;
    int n_fail;
    int mode;
    int period;
    int wait_cnt;

    judge_scan_ctrl #(.NUM_POS(7), .NUM_TPL(16), .DIFF_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .cmp_req    (cmp_req),
        .cmp_pos    (cmp_pos),
        .cmp_tpl    (cmp_tpl),
        .cmp_ack    (cmp_ack),
        .cmp_diff   (cmp_diff),
        .char_index (char_index),
        .char_diff  (char_diff),
        .char_valid (char_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Difference engine model: hand-chosen score patterns per mode.
    function automatic logic [15:0] model_diff(int m, logic [2:0] p, logic [3:0] t);
        logic [15:0] d;
        case (m)
            0: d = 16'd100 - {12'd0, t};
            1: d = (p == 3'd0 && (t == 4'd3 || t == 4'd9)) ? 16'd50 : 16'd200;
            2: d = 16'hFFFF;
            3: d = ({1'b0, t} == {2'b0, p} + 5'd2) ? 16'({13'd0, p} * 16'd10) : 16'd1000;
            default: d = (t == 4'd15) ? 16'hFFFE : 16'hFFFF;
        endcase
        return d;
    endfunction

    always_comb cmp_diff = model_diff(mode, cmp_pos, cmp_tpl);
    assign cmp_ack = cmp_req && (wait_cnt == period - 1);

    always @(posedge clk) begin
        if (!cmp_req || cmp_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int              mode;
        int              period;
        int              restart;
        int              done_cyc;
        logic [6:0][3:0]  idx;
        logic [6:0][15:0] diff;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(int m, int per, int rs, int dc, logic [3:0] i, logic [15:0] d);
        vec_t v;
        v.mode = m; v.period = per; v.restart = rs; v.done_cyc = dc;
        for (int k = 0; k < 7; k++) begin
            v.idx[k]  = i;
            v.diff[k] = d;
        end
        return v;
    endfunction

    // Runs one frame from a start pulse, checking strobes, handshake
    // stability and the frame_done cycle.
    task automatic run_frame(input vec_t v);
        int cyc;
        int n_strobe;
        logic [2:0] prev_pos;
        logic [3:0] prev_tpl;
        logic prev_wait;
        bit got_done;
        mode = v.mode;
        period = v.period;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        n_strobe = 0;
        prev_wait = 1'b0;
        prev_pos = 3'd0;
        prev_tpl = 4'd0;
        got_done = 1'b0;
        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (v.restart != 0 && cyc == v.restart);
            if (cyc == 1) chk("req_at_cycle1", {31'd0, cmp_req}, 32'd1);
            if (prev_wait) begin
                chk("hold_pos", {29'd0, cmp_pos}, {29'd0, prev_pos});
                chk("hold_tpl", {28'd0, cmp_tpl}, {28'd0, prev_tpl});
            end
            prev_wait = cmp_req && !cmp_ack;
            prev_pos = cmp_pos;
            prev_tpl = cmp_tpl;
            if (char_valid != 7'd0) begin
                if (n_strobe < 7) begin
                    chk("strobe_onehot", {25'd0, char_valid}, 32'd1 << n_strobe);
                    chk("char_index", {28'd0, char_index}, {28'd0, v.idx[n_strobe]});
                    chk("char_diff", {16'd0, char_diff}, {16'd0, v.diff[n_strobe]});
                end
                n_strobe++;
            end
            if (frame_done) begin
                got_done = 1'b1;
                chk("done_cycle", cyc, v.done_cyc);
            end
        end
        start = 1'b0;
        chk("frame_finished", {31'd0, got_done}, 32'd1);
        chk("strobe_count", n_strobe, 7);
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("held_index", {28'd0, char_index}, {28'd0, v.idx[6]});
    endtask

    initial begin
        int cyc;
        int n_str;
        int n_done;
        n_checks = 0;
        n_fail = 0;
        mode = 0;
        period = 1;
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b1;

        vecs[0] = mk(0, 1, 0, 120, 4'd15, 16'd85);
        vecs[1] = mk(1, 1, 0, 120, 4'd0, 16'd200);
        vecs[1].idx[0] = 4'd3;
        vecs[1].diff[0] = 16'd50;
        vecs[2] = mk(0, 3, 0, 7 * (16 * 3 + 1) + 1, 4'd15, 16'd85);
        vecs[3] = mk(2, 1, 50, 120, 4'd0, 16'hFFFF);
        vecs[4] = mk(3, 2, 0, 7 * (16 * 2 + 1) + 1, 4'd0, 16'd0);
        for (int k = 0; k < 7; k++) begin
            vecs[4].idx[k]  = 4'(k + 2);
            vecs[4].diff[k] = 16'(k * 10);
        end
        vecs[5] = mk(4, 1, 0, 120, 4'd15, 16'hFFFE);

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, cmp_req}, 32'd0);
        chk("rst_valid", {25'd0, char_valid}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_index", {28'd0, char_index}, 32'd0);
        chk("rst_diff", {16'd0, char_diff}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            run_frame(vecs[r]);
        end

        // Abort in the middle of position 3's template sweep.
        mode = 0;
        period = 1;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        n_str = 0;
        n_done = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = (cyc == 60);
            if (cyc == 60) chk("abort_pos3", {29'd0, cmp_pos}, 32'd3);
            if (cyc == 61) chk("abort_busy", {31'd0, busy}, 32'd0);
            if (char_valid != 7'd0) n_str++;
            if (frame_done) n_done++;
        end
        abort = 1'b0;
        chk("abort_strobes", n_str, 3);
        chk("abort_no_done", n_done, 0);
        run_frame(vecs[0]);

        // Abort and start together in IDLE: the start is dropped.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-frame at cycle 40.
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk("pre_rst_index", {28'd0, char_index}, 32'd15);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_req", {31'd0, cmp_req}, 32'd0);
        chk("arst_pos", {29'd0, cmp_pos}, 32'd0);
        chk("arst_tpl", {28'd0, cmp_tpl}, 32'd0);
        chk("arst_index", {28'd0, char_index}, 32'd0);
        chk("arst_diff", {16'd0, char_diff}, 32'd0);
        chk("arst_valid", {25'd0, char_valid}, 32'd0);
        chk("arst_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_str = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy || char_valid != 7'd0 || frame_done) n_str++;
        end
        chk("stay_idle_after_rst", n_str, 0);
        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
